d_cache_line_mover: RTL and testbench

Line-transfer sequencer for the D-cache data array: it is the initiator that drives the byte-write data RAM's single port (address, 64-bit write data, 8-bit byte enables, 1-cycle registered read data). On a refill request it streams memory beats into one cache line. On a writeback request it reads a line out word by word and streams the words to memory with valid/ready backpressure. It sits between the D-cache controller FSM and the memory-side bus adapter.

---
 rtl/d_cache_line_mover.sv | 135 +++++++++++++
 tb/tb_d_cache_line_mover.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_cache_line_mover.sv
// d_cache_line_mover: line-transfer sequencer for the D-cache data array.
// Refill streams memory beats into one cache line. Writeback reads the line
// word by word through the RAM's one-cycle registered read port and streams
// the words to memory under valid/ready backpressure.
module d_cache_line_mover #(
    parameter int ADDR_W = 6,
    parameter int BEAT_W = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic                       req_wb_i,
    input  logic [ADDR_W-BEAT_W-1:0]   req_line_i,
    output logic                       done_o,
    output logic [ADDR_W-1:0]          ram_addr_o,
    output logic [63:0]                ram_wdata_o,
    output logic [7:0]                 ram_wen_o,
    input  logic [63:0]                ram_rdata_i,
    input  logic                       rf_valid_i,
    input  logic [63:0]                rf_data_i,
    output logic                       rf_ready_o,
    output logic                       wb_valid_o,
    output logic [63:0]                wb_data_o,
    output logic                       wb_last_o,
    input  logic                       wb_ready_i
);

    localparam int LINE_W = ADDR_W - BEAT_W;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RF      = 3'd1;
    localparam logic [2:0] S_WB_RD   = 3'd2;
    localparam logic [2:0] S_WB_SEND = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]        state;
    logic [LINE_W-1:0] line;
    logic [BEAT_W-1:0] cnt;
    logic              last_beat;

    // The terminating beat is the one at the last word of the line.
    assign last_beat = &cnt;

    // Sequencer state, latched line index and word counter.
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            line  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        line  <= req_line_i;
                        cnt   <= '0;
                        state <= req_wb_i ? S_WB_RD : S_RF;
                    end
                end
                S_RF: begin
                    if (rf_valid_i) begin
                        // cnt wraps back to zero on the terminating beat.
                        cnt <= cnt + 1'b1;
                        if (last_beat) state <= S_DONE;
                    end
                end
                S_WB_RD: begin
                    // Address is presented this cycle; read data arrives next.
                    state <= S_WB_SEND;
                end
                S_WB_SEND: begin
                    if (wb_ready_i) begin
                        cnt   <= cnt + 1'b1;
                        state <= last_beat ? S_DONE : S_WB_RD;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Output decode from the current state; RAM writes are gated off in reset.
    // NOTE: every output gets a default first, so no path through the block
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        req_ready_o = 1'b0;
        done_o      = 1'b0;
        rf_ready_o  = 1'b0;
        wb_valid_o  = 1'b0;
        wb_last_o   = 1'b0;
        ram_addr_o  = '0;
        ram_wen_o   = 8'h00;
        ram_wdata_o = '0;
        wb_data_o   = ram_rdata_i;
        case (state)
            S_IDLE: begin
                req_ready_o = 1'b1;
            end
            S_RF: begin
                rf_ready_o = 1'b1;
                ram_addr_o = {line, cnt};
                // Refills always write whole words; the data is a straight
                // pass-through of the memory beat.
                if (rf_valid_i && rst) begin
                    ram_wen_o   = 8'hFF;
                    ram_wdata_o = rf_data_i;
                end
            end
            S_WB_RD: begin
                ram_addr_o = {line, cnt};
            end
            S_WB_SEND: begin
                // Address held and no writes, so read data is stable under stall.
                ram_addr_o = {line, cnt};
                wb_valid_o = 1'b1;
                wb_last_o  = last_beat;
            end
            S_DONE: begin
                done_o     = 1'b1;
                ram_addr_o = {line, cnt};
            end
            default: begin
                req_ready_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_d_cache_line_mover.sv
// Testbench for d_cache_line_mover: a behavioural byte-write RAM with a
// registered read port, a word-level expected-memory model and directed plus
// randomized refill/writeback transactions.
module tb_d_cache_line_mover;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_wb_i;
    logic [3:0]  req_line_i;
    logic        done_o;
    logic [5:0]  ram_addr_o;
    logic [63:0] ram_wdata_o;
    logic [7:0]  ram_wen_o;
    logic [63:0] ram_rdata_i;
    logic        rf_valid_i;
    logic [63:0] rf_data_i;
    logic        rf_ready_o;
    logic        wb_valid_o;
    logic [63:0] wb_data_o;
    logic        wb_last_o;
    logic        wb_ready_i;

    int tests = 0;
    int fails = 0;

    logic [63:0] ram     [64];
    logic [63:0] exp_mem [64];
    logic [63:0] bd      [4];
    int          gap     [4];
    int          stall   [4];

    always #5 clk = ~clk;

    d_cache_line_mover #(.ADDR_W(6), .BEAT_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_wb_i    (req_wb_i),
        .req_line_i  (req_line_i),
        .done_o      (done_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_wen_o   (ram_wen_o),
        .ram_rdata_i (ram_rdata_i),
        .rf_valid_i  (rf_valid_i),
        .rf_data_i   (rf_data_i),
        .rf_ready_o  (rf_ready_o),
        .wb_valid_o  (wb_valid_o),
        .wb_data_o   (wb_data_o),
        .wb_last_o   (wb_last_o),
        .wb_ready_i  (wb_ready_i)
    );

    // Byte-write data RAM with one-cycle registered read.
    always @(posedge clk) begin
        for (int b = 0; b < 8; b++)
            if (ram_wen_o[b]) ram[ram_addr_o][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
        ram_rdata_i <= ram[ram_addr_o];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and scramble inputs the DUT must ignore.
    task automatic nxt();
        @(negedge clk);
        req_valid_i = 1'($urandom);
        req_wb_i    = 1'($urandom);
        req_line_i  = 4'($urandom);
        rf_valid_i  = 1'($urandom);
        rf_data_i   = {$urandom, $urandom};
        wb_ready_i  = 1'($urandom);
    endtask

    // Present a request in IDLE; the following posedge is cycle 0.
    task automatic request(input logic wb, input logic [3:0] line);
        logic seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            nxt();
            req_valid_i = 1'b1;
            req_wb_i    = wb;
            req_line_i  = line;
            #1;
            seen = req_ready_o;
        end
        check("req_ready", req_ready_o, 1'b1);
    endtask

    // DONE cycle followed by the first IDLE cycle.
    task automatic finish_checks(input string kind);
        check({kind, "_done"}, done_o, 1'b1);
        check({kind, "_done_not_ready"}, req_ready_o, 1'b0);
        check({kind, "_done_wen"}, ram_wen_o, 8'h00);
        nxt();
        req_valid_i = 1'b0;
        #1;
        check({kind, "_idle_ready"}, req_ready_o, 1'b1);
        check({kind, "_idle_done"}, done_o, 1'b0);
        check({kind, "_idle_addr"}, ram_addr_o, 6'd0);
    endtask

    task automatic readback(input logic [3:0] line);
        for (int i = 0; i < 4; i++)
            check("ram_readback", ram[{line, 2'(i)}], exp_mem[{line, 2'(i)}]);
    endtask

    // Refill one line with beats bd[] and gap[i] idle cycles before beat i.
    task automatic do_refill(input logic [3:0] line);
        request(1'b0, line);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gap[i]; g++) begin
                nxt();
                rf_valid_i = 1'b0;
                #1;
                check("rf_gap_ready", rf_ready_o, 1'b1);
                check("rf_gap_wen", ram_wen_o, 8'h00);
                check("rf_gap_wdata", ram_wdata_o, 64'd0);
                check("rf_gap_addr", ram_addr_o, {line, 2'(i)});
                check("rf_gap_done", done_o, 1'b0);
            end
            nxt();
            rf_valid_i = 1'b1;
            rf_data_i  = bd[i];
            #1;
            check("rf_wen", ram_wen_o, 8'hFF);
            check("rf_wdata", ram_wdata_o, bd[i]);
            check("rf_addr", ram_addr_o, {line, 2'(i)});
            check("rf_done_early", done_o, 1'b0);
            exp_mem[{line, 2'(i)}] = bd[i];
        end
        nxt();
        #1;
        finish_checks("rf");
        readback(line);
    endtask

    // Write back one line with stall[k] not-ready cycles on beat k.
    task automatic do_wb(input logic [3:0] line);
        int cyc = 0;
        int total = 0;
        int remaining;
        logic found;
        request(1'b1, line);
        for (int k = 0; k < 4; k++) begin
            found = 1'b0;
            for (int w = 0; w < 4 && !found; w++) begin
                nxt();
                cyc++;
                wb_ready_i = 1'b0;
                #1;
                found = wb_valid_o;
                if (!found) check("wb_rd_wen", ram_wen_o, 8'h00);
            end
            if (!found) begin
                check("wb_valid_timeout", wb_valid_o, 1'b1);
                return;
            end
            check("wb_beat_cycle", 64'(cyc), 64'(2 + 2 * k + total));
            remaining = stall[k];
            wb_ready_i = (remaining == 0);
            #1;
            forever begin
                check("wb_valid", wb_valid_o, 1'b1);
                check("wb_data", wb_data_o, exp_mem[{line, 2'(k)}]);
                check("wb_last", wb_last_o, (k == 3));
                check("wb_addr", ram_addr_o, {line, 2'(k)});
                check("wb_wen", ram_wen_o, 8'h00);
                if (remaining == 0) break;
                remaining--;
                nxt();
                cyc++;
                wb_ready_i = (remaining == 0);
                #1;
            end
            total += stall[k];
        end
        nxt();
        cyc++;
        #1;
        check("wb_done_cycle", 64'(cyc), 64'(2 * 4 + 1 + total));
        check("wb_done_valid", wb_valid_o, 1'b0);
        finish_checks("wb");
    endtask

    initial begin
        rst         = 1'b0;
        req_valid_i = 1'b1;
        req_wb_i    = 1'b0;
        req_line_i  = 4'd0;
        rf_valid_i  = 1'b1;
        rf_data_i   = 64'hDEAD_BEEF_0000_0001;
        wb_ready_i  = 1'b0;

        // Reset with refill and request inputs held high.
        #1;
        check("rst_wen_t0", ram_wen_o, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("rst_wen", ram_wen_o, 8'h00);
        end
        check("rst_ready", req_ready_o, 1'b1);
        @(negedge clk);
        rst         = 1'b1;
        req_valid_i = 1'b0;
        rf_valid_i  = 1'b0;
        #1;
        check("post_rst_ready", req_ready_o, 1'b1);
        check("post_rst_done", done_o, 1'b0);
        check("post_rst_rf_ready", rf_ready_o, 1'b0);
        check("post_rst_wb_valid", wb_valid_o, 1'b0);
        check("post_rst_wb_last", wb_last_o, 1'b0);
        check("post_rst_addr", ram_addr_o, 6'd0);
        check("post_rst_wdata", ram_wdata_o, 64'd0);
        check("post_rst_wen", ram_wen_o, 8'h00);

        // Randomized refill of every line to preload the RAM.
        for (int l = 0; l < 16; l++) begin
            for (int i = 0; i < 4; i++) begin
                bd[i]  = {$urandom, $urandom};
                gap[i] = $urandom_range(0, 2);
            end
            do_refill(4'(l));
        end

        // Line 3, no stall: done in cycle 5.
        bd[0] = 64'h1111_1111_1111_1111;
        bd[1] = 64'h2222_2222_2222_2222;
        bd[2] = 64'h3333_3333_3333_3333;
        bd[3] = 64'h4444_4444_4444_4444;
        for (int i = 0; i < 4; i++) gap[i] = 0;
        do_refill(4'd3);

        // Line 5, three idle cycles while the address sits at word 1.
        for (int i = 0; i < 4; i++) begin
            bd[i]  = {$urandom, $urandom};
            gap[i] = (i == 1) ? 3 : 0;
        end
        do_refill(4'd5);

        // Writeback line 3, always ready: done in cycle 9.
        for (int k = 0; k < 4; k++) stall[k] = 0;
        do_wb(4'd3);

        // Writeback line 5 with a 4-cycle stall on the second beat.
        for (int k = 0; k < 4; k++) stall[k] = (k == 1) ? 4 : 0;
        do_wb(4'd5);

        // Randomized writebacks.
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < 4; k++) stall[k] = $urandom_range(0, 3);
            do_wb(4'($urandom_range(0, 15)));
        end

        // Reset during the third refill beat of line 7.
        request(1'b0, 4'd7);
        for (int i = 0; i < 2; i++) begin
            nxt();
            rf_valid_i = 1'b1;
            rf_data_i  = {$urandom, $urandom};
            exp_mem[{4'd7, 2'(i)}] = rf_data_i;
            #1;
            check("abort_rf_wen", ram_wen_o, 8'hFF);
        end
        nxt();
        rf_valid_i = 1'b1;
        rst        = 1'b0;
        #1;
        check("abort_wen_forced", ram_wen_o, 8'h00);
        nxt();
        rf_valid_i = 1'b1;
        #1;
        check("abort_no_done", done_o, 1'b0);
        check("abort_idle", req_ready_o, 1'b1);
        check("abort_rf_ready", rf_ready_o, 1'b0);
        check("abort_wen", ram_wen_o, 8'h00);
        nxt();
        rst         = 1'b1;
        req_valid_i = 1'b0;
        #1;
        check("abort_release_ready", req_ready_o, 1'b1);
        check("abort_release_done", done_o, 1'b0);
        readback(4'd7);
        for (int k = 0; k < 4; k++) stall[k] = 0;
        do_wb(4'd7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
